// File: rtl/text_reveal_ctrl_pkg.sv
// Shared types and constants for the letter-reveal controller and its frame divider.
package text_reveal_ctrl_pkg;
  localparam int NUM_SLOTS = 8;
  localparam int COORD_W   = 10;
  localparam int GLYPH_W   = 32;
  localparam int GLYPH_H   = 40;
  localparam int CNT_W     = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REVEAL = 2'd1,
    ST_BLINK  = 2'd2,
    ST_HOLD   = 2'd3
  } state_e;

  // Thermometer mask of the first n slots.
  function automatic logic [NUM_SLOTS-1:0] slot_mask(input logic [3:0] n);
    logic [NUM_SLOTS-1:0] m;
    m = '0;
    for (int i = 0; i < NUM_SLOTS; i++)
      if (4'(i) < n) m[i] = 1'b1;
    return m;
  endfunction
endpackage

// File: rtl/text_reveal_ctrl_frame_div.sv
// Counts frame ticks against a programmable limit; term pulses on the tick that completes the period.
module frame_div
  import text_reveal_ctrl_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         run,
  input  logic         tick,
  input  logic [W-1:0] limit,
  output logic         term
);
  logic [W-1:0] cnt;

  // A clear wins over a coincident tick, so that tick is simply lost.
  assign term = run && tick && !clr && (cnt == limit - W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              cnt <= '0;
    else if (clr)            cnt <= '0;
    else if (run && tick)    cnt <= term ? '0 : cnt + W'(1);
  end
endmodule

// File: rtl/text_reveal_ctrl.sv
// Sequences glyph enables: reveal letters one at a time, blink the word, then hold it lit.
module text_reveal_ctrl
  import text_reveal_ctrl_pkg::*;
#(
  parameter int REVEAL_FRAMES = 15,
  parameter int BLINK_FRAMES  = 30,
  parameter int BLINK_COUNT   = 3,
  parameter int PITCH         = 40
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           frame_tick,
  input  logic                           start,
  input  logic                           clear,
  input  logic [3:0]                     num_letters,
  input  logic [COORD_W-1:0]             base_x,
  input  logic [COORD_W-1:0]             base_y,
  output logic [NUM_SLOTS-1:0]           en,
  output logic [NUM_SLOTS*COORD_W-1:0]   slot_x0,
  output logic [COORD_W-1:0]             y0,
  output logic                           busy,
  output logic                           done
);
  localparam logic [4:0] BLINK_LAST = (BLINK_COUNT == 0) ? 5'd0 : 5'(2*BLINK_COUNT - 1);

  state_e         state, state_nxt;
  logic [3:0]     num_q;
  logic [3:0]     lit_cnt;
  logic [4:0]     blink_cnt;
  logic           legal_start, run, term, done_set;
  logic [CNT_W-1:0] limit;
  logic [NUM_SLOTS-1:0] mask;

  assign legal_start = start && (num_letters != 4'd0) && (num_letters <= 4'(NUM_SLOTS));
  assign run         = (state == ST_REVEAL) || (state == ST_BLINK);
  assign limit       = (state == ST_BLINK) ? CNT_W'(BLINK_FRAMES) : CNT_W'(REVEAL_FRAMES);
  assign mask        = slot_mask(num_q);

  frame_div #(.W(CNT_W)) u_div (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clear || legal_start),
    .run   (run),
    .tick  (frame_tick),
    .limit (limit),
    .term  (term)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (clear)            state_nxt = ST_IDLE;
    else if (legal_start) state_nxt = ST_REVEAL;
    else begin
      case (state)
        ST_REVEAL: if (term && lit_cnt >= num_q) state_nxt = ST_BLINK;
        ST_BLINK:  if (BLINK_COUNT == 0 || (term && blink_cnt == BLINK_LAST)) state_nxt = ST_HOLD;
        default:   state_nxt = state;
      endcase
    end
  end

  always_comb begin
    busy     = run;
    done_set = (state_nxt == ST_HOLD) && (state != ST_HOLD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done      <= 1'b0;
      en        <= '0;
      num_q     <= '0;
      lit_cnt   <= '0;
      blink_cnt <= '0;
      y0        <= '0;
      slot_x0   <= '0;
    end else begin
      done <= done_set;
      if (clear) begin
        en <= '0;
      end else if (legal_start) begin
        num_q     <= num_letters;
        en        <= NUM_SLOTS'(1);
        lit_cnt   <= 4'd1;
        blink_cnt <= '0;
        y0        <= base_y;
        // Slot origins wrap at 10 bits by truncation.
        for (int i = 0; i < NUM_SLOTS; i++)
          slot_x0[i*COORD_W +: COORD_W] <= base_x + COORD_W'(i*PITCH);
      end else begin
        case (state)
          ST_REVEAL: if (term && lit_cnt < num_q) begin
            en[lit_cnt[2:0]] <= 1'b1;
            lit_cnt          <= lit_cnt + 4'd1;
          end
          ST_BLINK: begin
            if (BLINK_COUNT == 0) en <= mask;
            else if (term) begin
              blink_cnt <= blink_cnt + 5'd1;
              en        <= (blink_cnt == BLINK_LAST) ? mask : (en ^ mask);
            end
          end
          default: en <= en;
        endcase
      end
    end
  end
endmodule

// File: doc/text_reveal_ctrl.md
TEXT_REVEAL_CTRL -- requirements
Module: text_reveal_ctrl

Interface
REQ-001 Parameters (name, default, meaning): REVEAL_FRAMES, 15, frame ticks between successive letter reveals (legal 1..255).
REQ-002 BLINK_FRAMES, 30, frame ticks per blink half-period (legal 1..255).
REQ-003 BLINK_COUNT, 3, number of full off/on blink cycles after the last reveal (legal 0..15).
REQ-004 PITCH, 40, horizontal pixel spacing between letter slots (32-pixel glyph plus 8-pixel gap).
REQ-005 Ports, listed as name, direction, width, meaning.
- clk, in, 1, pixel clock, the only clock.
- rst_n, in, 1, asynchronous active-low reset.
REQ-006 frame_tick, in, 1: one-cycle pulse once per video frame.
REQ-007 start, in, 1: one-cycle pulse that launches or relaunches the reveal sequence.
REQ-008 clear, in, 1: one-cycle pulse that blanks the text and returns the block to IDLE.
REQ-009 num_letters, in, 4: letter count, legal 1..8, sampled on start.
REQ-010 base_x and base_y, in, 10 each: top-left pixel of slot 0, sampled on start.
REQ-011 en, out, 8: per-slot glyph enable, driven to the glyph renderers' en inputs.
REQ-012 slot_x0, out, 80: packed slot origins; slot i occupies bits [10i+9:10i].
REQ-013 y0, out, 10: common row origin for all slots.
REQ-014 busy, out, 1: high while in REVEAL or BLINK.
REQ-015 done, out, 1: one-cycle pulse on entry to HOLD.

Function
REQ-016 States SHALL be IDLE, REVEAL, BLINK and HOLD.
REQ-017 A start with num_letters equal to 0 or greater than 8 SHALL be ignored.
REQ-018 A legal start in any state SHALL do all of the following:
- latch num_letters, base_x and base_y;
- clear the frame counter and blink counter;
- set en to 8'b0000_0001 in the next cycle;
- enter REVEAL.
REQ-019 The frame counter SHALL advance only on cycles where frame_tick is high; ticks in IDLE and HOLD SHALL be ignored.
REQ-020 In REVEAL, the frame_tick that completes REVEAL_FRAMES ticks SHALL do one of the following, and zero the counter:
- if fewer than num_letters slots are lit, light the next slot (en[k] set) in the following cycle;
- otherwise, enter BLINK.
REQ-021 In BLINK, every BLINK_FRAMES ticks SHALL toggle all slots below num_letters between off and on.
- After 2*BLINK_COUNT toggles, ending lit, the block SHALL enter HOLD.
- With BLINK_COUNT=0, BLINK SHALL exit to HOLD on its first cycle.
REQ-022 en bits at index num_letters and above SHALL be 0 in every state.
REQ-023 HOLD SHALL keep all num_letters slots lit until start or clear.
REQ-024 clear SHALL zero en and enter IDLE in the next cycle from any state; it takes priority over a simultaneous start.
REQ-025 A start coincident with frame_tick SHALL restart the sequence and discard that tick.
REQ-026 slot_x0[i] SHALL equal (latched base_x + i*PITCH) mod 1024, i.e. 10-bit wrap, registered.
REQ-027 y0 SHALL equal latched base_y.

Reset
REQ-028 On rst_n low, asynchronously, the block SHALL be forced to:
- state IDLE;
- en, busy, done, counters and latched base_x/base_y all 0;
- so slot_x0 and y0 read 0.
REQ-029 Reset deassertion mid-sequence SHALL resume from IDLE only; no sequence state is retained.

Structure
REQ-030 A shared package SHALL hold:
- the state enum;
- NUM_SLOTS=8;
- COORD_W=10;
- GLYPH_W=32 and GLYPH_H=40 constants.
REQ-031 A single sub-module, frame_div, SHALL count frame_ticks against a programmable limit, with sync clear, and emit a terminal pulse; it is reused for the REVEAL and BLINK periods.

Verification
REQ-032 Scenario: REVEAL_FRAMES=2, BLINK_COUNT=1, BLINK_FRAMES=1, num_letters=3, start.
- Required en after start, frame tick by tick: 001, 001, 011, 011, 111, 111.
- Then BLINK: 000, 111.
- Then HOLD, with done pulsing exactly once.
REQ-033 Scenario: base_x=1000, num_letters=2, start -> slot_x0[0]=1000, slot_x0[1]=16 (wrap).
REQ-034 Scenario: start with num_letters=0, and separately with 9 -> state stays IDLE, en=0, busy=0.
REQ-035 Scenario: clear and start asserted in the same cycle during BLINK -> IDLE, en=0, no done pulse.
REQ-036 Scenario: rst_n pulled low during REVEAL with en=011 -> en=0 immediately, without waiting for a clock edge; after release, state IDLE.
REQ-037 Scenario: start retriggered in HOLD with num_letters=5 -> en=00001 next cycle, busy=1.
